// File: rtl/uart_pkg.sv
// Shared types and helpers for the histogram-readout UART receiver.
// Bit-FSM states, record byte slots, default oversample rate, parity.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] SLOT_ADDR_HI = 2'd0;
  localparam logic [1:0] SLOT_ADDR_LO = 2'd1;
  localparam logic [1:0] SLOT_DATA_HI = 2'd2;
  localparam logic [1:0] SLOT_DATA_LO = 2'd3;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Oversampled UART character receiver: sync, start check, bit FSM.
// Emits one byte_valid pulse on the stop-bit sample tick.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rxd,
  input  logic       i_rx_en,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_par_err,
  output logic       o_frm_err,
  output logic       o_idle,
  output logic       o_line
);

  localparam int TW = $clog2(OVERSAMPLE);

  logic [1:0]    r_sync;
  rx_state_e     r_state, w_state_n;
  logic [TW-1:0] r_tick, w_tick_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_data, w_data_n;
  logic          r_par, w_par_n;
  logic          r_armed, w_armed_n;
  logic          w_rx, w_mid, w_half;
  logic          w_bv, w_frm;

  assign w_rx   = r_sync[1];
  assign w_mid  = (r_tick == TW'(OVERSAMPLE - 1));
  assign w_half = (r_tick == TW'(OVERSAMPLE / 2 - 1));

  // Two-flop synchronizer, preset to the idle level
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], i_rxd};
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_data  <= w_data_n;
      r_par   <= w_par_n;
      r_armed <= w_armed_n;
    end
  end

  // Next state; every decision is gated by the oversample tick
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_data_n  = r_data;
    w_par_n   = r_par;
    w_armed_n = r_armed;
    w_bv      = 1'b0;
    w_frm     = 1'b0;
    if (i_rx_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_rx) begin
            w_armed_n = 1'b1;
          end else if (r_armed) begin
            w_state_n = ST_START;
            w_tick_n  = '0;
            w_armed_n = 1'b0;
          end
        end
        ST_START: begin
          if (!w_half) begin
            w_tick_n = r_tick + TW'(1);
          end else if (w_rx) begin
            w_state_n = ST_IDLE;
            w_armed_n = 1'b1;
          end else begin
            w_state_n = ST_DATA;
            w_tick_n  = '0;
            w_bit_n   = '0;
          end
        end
        ST_DATA: begin
          if (!w_mid) begin
            w_tick_n = r_tick + TW'(1);
          end else begin
            w_data_n[r_bit] = w_rx;
            w_tick_n = '0;
            w_bit_n  = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_n = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (!w_mid) begin
            w_tick_n = r_tick + TW'(1);
          end else begin
            w_par_n   = w_rx ^ even_par(r_data);
            w_tick_n  = '0;
            w_state_n = ST_STOP;
          end
        end
        ST_STOP: begin
          if (!w_mid) begin
            w_tick_n = r_tick + TW'(1);
          end else begin
            w_bv      = 1'b1;
            w_frm     = ~w_rx;
            w_armed_n = w_rx;
            w_tick_n  = '0;
            w_state_n = ST_IDLE;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign o_byte_valid = w_bv;
  assign o_byte       = r_data;
  assign o_par_err    = r_par;
  assign o_frm_err    = w_frm;
  assign o_idle       = (r_state == ST_IDLE);
  assign o_line       = w_rx;

endmodule

// File: rtl/uart_rx_frame.sv
// Reassembles 4-byte address/data records from the readout UART.
// Flags record errors, resyncs on long idle, checks address sequence.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int WIDTH_DATA       = 16,
  parameter int LENGTH_ADDR      = 10,
  parameter int OVERSAMPLE       = OVERSAMPLE_DEF,
  parameter int IDLE_RESYNC_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RxD,
  input  logic                   rx_en,
  output logic                   rec_valid,
  output logic [LENGTH_ADDR-1:0] rec_addr,
  output logic [WIDTH_DATA-1:0]  rec_data,
  output logic                   rec_err,
  output logic                   err_par,
  output logic                   err_frm,
  output logic                   err_fmt,
  output logic                   seq_gap,
  output logic                   busy
);

  localparam int AHW = LENGTH_ADDR - 8;
  localparam int DHW = WIDTH_DATA - 8;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int RSW = $clog2(IDLE_RESYNC_BITS + 1);

  logic                   w_bv, w_bpar, w_bfrm, w_idle, w_line;
  logic [7:0]             w_byte;
  logic [1:0]             r_idx;
  logic [AHW-1:0]         r_addr_hi;
  logic [7:0]             r_addr_lo;
  logic [DHW-1:0]         r_data_hi;
  logic                   r_fpar, r_ffrm, r_ffmt, r_first;
  logic [TW-1:0]          r_rs_tick;
  logic [RSW-1:0]         r_rs_bits;
  logic                   w_fpar, w_ffrm, w_ffmt, w_any;
  logic                   w_quiet, w_timeout;
  logic [LENGTH_ADDR-1:0] w_addr, w_next;

  uart_rx_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (RxD),
    .i_rx_en     (rx_en),
    .o_byte_valid(w_bv),
    .o_byte      (w_byte),
    .o_par_err   (w_bpar),
    .o_frm_err   (w_bfrm),
    .o_idle      (w_idle),
    .o_line      (w_line)
  );

  assign busy      = ~w_idle;
  assign w_quiet   = w_idle & w_line;
  assign w_timeout = rx_en & w_quiet &
                     (r_rs_tick == TW'(OVERSAMPLE - 1)) &
                     (r_rs_bits == RSW'(IDLE_RESYNC_BITS - 1));

  assign w_fpar = r_fpar | w_bpar;
  assign w_ffrm = r_ffrm | w_bfrm;
  assign w_ffmt = r_ffmt |
                  ((r_idx == SLOT_ADDR_HI) & (|w_byte[7:AHW]));
  assign w_any  = w_fpar | w_ffrm | w_ffmt;
  assign w_addr = {r_addr_hi, r_addr_lo};
  assign w_next = rec_addr + LENGTH_ADDR'(1);

  // Count whole bit periods of quiet line while the bit FSM idles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs_tick <= '0;
      r_rs_bits <= '0;
    end else if (rx_en) begin
      if (!w_quiet) begin
        r_rs_tick <= '0;
        r_rs_bits <= '0;
      end else if (r_rs_tick == TW'(OVERSAMPLE - 1)) begin
        r_rs_tick <= '0;
        if (r_rs_bits != RSW'(IDLE_RESYNC_BITS))
          r_rs_bits <= r_rs_bits + RSW'(1);
      end else begin
        r_rs_tick <= r_rs_tick + TW'(1);
      end
    end
  end

  // Slot commit, record completion and sequence check
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= SLOT_ADDR_HI;
      r_addr_hi <= '0;
      r_addr_lo <= '0;
      r_data_hi <= '0;
      r_fpar    <= 1'b0;
      r_ffrm    <= 1'b0;
      r_ffmt    <= 1'b0;
      r_first   <= 1'b1;
      rec_valid <= 1'b0;
      rec_err   <= 1'b0;
      rec_addr  <= '0;
      rec_data  <= '0;
      err_par   <= 1'b0;
      err_frm   <= 1'b0;
      err_fmt   <= 1'b0;
      seq_gap   <= 1'b0;
    end else begin
      rec_valid <= 1'b0;
      rec_err   <= 1'b0;
      if (w_timeout && r_idx != SLOT_ADDR_HI) begin
        r_idx  <= SLOT_ADDR_HI;
        r_fpar <= 1'b0;
        r_ffrm <= 1'b0;
        r_ffmt <= 1'b0;
      end else if (w_bv) begin
        r_idx  <= r_idx + 2'd1;
        r_fpar <= w_fpar;
        r_ffrm <= w_ffrm;
        r_ffmt <= w_ffmt;
        unique case (r_idx)
          SLOT_ADDR_HI: r_addr_hi <= w_byte[AHW-1:0];
          SLOT_ADDR_LO: r_addr_lo <= w_byte;
          SLOT_DATA_HI: r_data_hi <= w_byte[DHW-1:0];
          SLOT_DATA_LO: begin
            r_fpar  <= 1'b0;
            r_ffrm  <= 1'b0;
            r_ffmt  <= 1'b0;
            err_par <= w_fpar;
            err_frm <= w_ffrm;
            err_fmt <= w_ffmt;
            if (w_any) begin
              rec_err <= 1'b1;
            end else begin
              rec_valid <= 1'b1;
              rec_addr  <= w_addr;
              rec_data  <= {r_data_hi, w_byte};
              seq_gap   <= ~r_first & (w_addr != w_next);
              r_first   <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: serial stimulus, record model.
// Directed records, error/glitch/resync/reset cases, random records.
module tb_uart_rx_frame;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RxD = 1'b1;
  logic        rx_en;
  logic        rec_valid, rec_err;
  logic [9:0]  rec_addr;
  logic [15:0] rec_data;
  logic        err_par, err_frm, err_fmt, seq_gap, busy;

  uart_rx_frame dut (
    .clk      (clk),
    .rst      (rst),
    .RxD      (RxD),
    .rx_en    (rx_en),
    .rec_valid(rec_valid),
    .rec_addr (rec_addr),
    .rec_data (rec_data),
    .rec_err  (rec_err),
    .err_par  (err_par),
    .err_frm  (err_frm),
    .err_fmt  (err_fmt),
    .seq_gap  (seq_gap),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    rx_en = 1'b0;
    forever begin
      @(negedge clk);
      rx_en = ~rx_en;
    end
  end

  typedef struct {
    bit          v;
    logic [9:0]  a;
    logic [15:0] d;
    bit          g, p, f, m;
  } ev_t;

  ev_t         expq[$];
  ev_t         e;
  logic [7:0]  mb[$];
  bit          acc_p, acc_f;
  bit          m_first = 1'b1;
  logic [9:0]  m_prev = '0;
  logic [9:0]  shown_a = '0;
  logic [15:0] shown_d = '0;
  bit          last_gap;
  logic [2:0]  last_err;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void model_byte(logic [7:0] b, bit pe, bit fe);
    ev_t        r;
    logic [9:0] a, nx;
    mb.push_back(b);
    acc_p |= pe;
    acc_f |= fe;
    if (mb.size() == 4) begin
      a   = {mb[0][1:0], mb[1]};
      nx  = m_prev + 10'd1;
      r.a = a;
      r.d = {mb[2], mb[3]};
      r.p = acc_p;
      r.f = acc_f;
      r.m = |mb[0][7:2];
      r.v = !(r.p || r.f || r.m);
      r.g = !m_first && (a != nx);
      if (r.v) begin
        m_first = 1'b0;
        m_prev  = a;
      end
      expq.push_back(r);
      mb.delete();
      acc_p = 1'b0;
      acc_f = 1'b0;
    end
  endfunction

  function automatic void model_resync();
    mb.delete();
    acc_p = 1'b0;
    acc_f = 1'b0;
  endfunction

  function automatic void model_reset();
    model_resync();
    expq.delete();
    m_first = 1'b1;
    m_prev  = '0;
    shown_a = '0;
    shown_d = '0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rec_valid && rec_err) chk("both_pulses", 1, 0);
      if (rec_valid || rec_err) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {rec_valid, rec_err}, 0);
        end else begin
          e = expq.pop_front();
          chk("kind", rec_valid, e.v);
          if (e.v) begin
            chk("addr", rec_addr, e.a);
            chk("data", rec_data, e.d);
            chk("seq_gap", seq_gap, e.g);
            shown_a  = e.a;
            shown_d  = e.d;
            last_gap = seq_gap;
          end else begin
            chk("err_flags", {err_par, err_frm, err_fmt},
                {e.p, e.f, e.m});
            last_err = {err_par, err_frm, err_fmt};
          end
        end
      end
      chk("addr_hold", rec_addr, shown_a);
      chk("data_hold", rec_data, shown_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    while (!rx_en) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, int n);
    RxD = v;
    repeat (n) tick();
  endtask

  task automatic send_char(logic [7:0] b, bit pinv, bit sbad);
    logic [10:0] f;
    f = {~sbad, (^b) ^ pinv, b, 1'b0};
    model_byte(b, pinv, sbad);
    for (int i = 0; i < 11; i++) drive(f[i], OS);
    RxD = 1'b1;
  endtask

  task automatic gap(int bits);
    drive(1'b1, bits * OS);
    if (bits > 20) model_resync();
  endtask

  task automatic send_rec(logic [9:0] a, logic [15:0] d,
                          int pidx, int sidx, logic [5:0] fm);
    logic [7:0] by [4];
    by[0] = {fm, a[9:8]};
    by[1] = a[7:0];
    by[2] = d[15:8];
    by[3] = d[7:0];
    for (int i = 0; i < 4; i++) begin
      send_char(by[i], i == pidx, i == sidx);
      gap(2);
    end
    chk("latency_drained", expq.size(), 0);
  endtask

  initial begin
    logic [9:0]  ra;
    logic [15:0] rd;
    int          k;
    repeat (4) @(negedge clk);
    chk("reset_outs",
        {rec_valid, rec_err, err_par, err_frm, err_fmt,
         seq_gap, busy, rec_addr, rec_data}, 0);
    rst = 1'b0;
    gap(2);

    send_rec(10'h2A5, 16'hBEEF, -1, -1, 6'd0);
    chk("lit_addr", rec_addr, 10'h2A5);
    chk("lit_data", rec_data, 16'hBEEF);
    chk("lit_gap0", last_gap, 0);

    send_rec(10'h000, 16'h1111, -1, -1, 6'd0);
    send_rec(10'h002, 16'h2222, -1, -1, 6'd0);
    chk("lit_gap1", last_gap, 1);
    send_rec(10'h3FF, 16'h3333, -1, -1, 6'd0);
    send_rec(10'h000, 16'h4444, -1, -1, 6'd0);
    chk("lit_wrap", last_gap, 0);

    send_rec(10'h111, 16'h5555, 2, -1, 6'd0);
    chk("lit_par", last_err, 3'b100);
    chk("lit_hold", rec_addr, 10'h000);
    send_rec(10'h001, 16'h6666, -1, -1, 6'd0);
    send_rec(10'h050, 16'h7777, -1, 1, 6'd0);
    chk("lit_frm", last_err, 3'b010);
    send_rec(10'h1AA, 16'h8888, -1, -1, 6'b010000);
    chk("lit_fmt", last_err, 3'b001);

    drive(1'b0, 4);
    gap(2);
    send_rec(10'h002, 16'h9999, -1, -1, 6'd0);

    send_char(8'h01, 0, 0);
    gap(2);
    send_char(8'h77, 0, 0);
    gap(25);
    send_rec(10'h001, 16'h1234, -1, -1, 6'd0);
    chk("lit_resync", rec_data, 16'h1234);

    send_char(8'h02, 0, 0);
    gap(2);
    send_char(8'h10, 0, 0);
    gap(2);
    drive(1'b0, 3 * OS);
    chk("busy_mid", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    RxD = 1'b1;
    rst = 1'b0;
    gap(2);
    send_rec(10'h123, 16'hCAFE, -1, -1, 6'd0);
    chk("lit_first", last_gap, 0);

    ra = 10'h123;
    for (int i = 0; i < 12; i++) begin
      ra = ($urandom_range(0, 1) != 0) ? ra + 10'd1
                                        : 10'($urandom);
      rd = 16'($urandom);
      k  = $urandom_range(0, 7);
      send_rec(ra, rd,
               (k == 0) ? $urandom_range(0, 3) : -1,
               (k == 1) ? $urandom_range(0, 3) : -1,
               (k == 2) ? 6'($urandom_range(1, 63)) : 6'd0);
    end

    gap(3);
    chk("queue_empty", expq.size(), 0);
    chk("idle_end", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
